// File: rtl/r4u3_twiddle_seq_if.sv
// rtl/r4u3_twiddle_seq_if.sv - sample-in / pair-out stream bundle for the unit-3 twiddle sequencer
// Purpose: groups the input sample stream and the output sample+twiddle stream.
// Ports (signals):
//   in_valid/in_ready/in_sof/in_data                     sample stream into the sequencer
//   out_valid/out_ready/out_sof/out_eof/out_data/
//   out_twiddle/out_idx                                   paired stream toward the multiplier
// Modports: master = stream source / pair sink (test side), slave = sequencer side.
`ifndef COEF_WIDTH
`define COEF_WIDTH 16
`endif

interface r4u3_twiddle_seq_if #(
   parameter int DATA_W = 16,
   parameter int CW     = `COEF_WIDTH
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_sof;
   logic [2*DATA_W-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_sof;
   logic                  out_eof;
   logic [2*DATA_W-1:0]   out_data;
   logic [2*CW-1:0]       out_twiddle;
   logic [6:0]            out_idx;

   modport master (
      output in_valid, in_sof, in_data, out_ready,
      input  in_ready, out_valid, out_sof, out_eof, out_data, out_twiddle, out_idx
   );

   modport slave (
      input  in_valid, in_sof, in_data, out_ready,
      output in_ready, out_valid, out_sof, out_eof, out_data, out_twiddle, out_idx
   );
endinterface

// File: rtl/r4u3_twiddle_seq.sv
// rtl/r4u3_twiddle_seq.sv - radix-4 unit-3 twiddle ROM read sequencer
// Purpose: tracks the in-frame sample index, addresses the 128-entry twiddle ROM on
// its 128-point grid and emits each sample paired with its twiddle through a
// two-stage stallable pipeline (S1 = address stage, S2 = registered output).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg_log2n      log2 frame length, sampled on accepted sof beats (0..3 clamp to 4)
//   strm           stream bundle (slave): samples in, {sample, twiddle, idx} pairs out
//   rom_addr       registered ROM address
//   rom_data       combinational ROM data for rom_addr
//   err_sof        one-cycle pulse when sof arrives mid-frame
`ifndef COEF_WIDTH
`define COEF_WIDTH 16
`endif

module r4u3_twiddle_seq #(
   parameter int DATA_W = 16,
   parameter int CW     = `COEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           cfg_log2n,
   r4u3_twiddle_seq_if.slave    strm,
   output logic [6:0]           rom_addr,
   input  logic [2*CW-1:0]      rom_data,
   output logic                 err_sof
);

   // frame tracking
   logic                 synced_q, synced_d;
   logic [2:0]           n_log2_q, n_log2_d;
   logic [6:0]           exp_idx_q, exp_idx_d;
   // S1
   logic                 s1_valid_q, s1_valid_d;
   logic [2*DATA_W-1:0]  s1_data_q, s1_data_d;
   logic [6:0]           s1_idx_q, s1_idx_d;
   logic                 s1_sof_q, s1_sof_d;
   logic                 s1_eof_q, s1_eof_d;
   logic [6:0]           rom_addr_q, rom_addr_d;
   // S2
   logic                 out_valid_q, out_valid_d;
   logic [2*DATA_W-1:0]  out_data_q, out_data_d;
   logic [2*CW-1:0]      out_twiddle_q, out_twiddle_d;
   logic [6:0]           out_idx_q, out_idx_d;
   logic                 out_sof_q, out_sof_d;
   logic                 out_eof_q, out_eof_d;
   logic                 err_sof_q, err_sof_d;

   logic                 adv1, adv2, accept, take, is_last;
   logic [2:0]           nl_cfg, cur_nl;
   logic [6:0]           cur_idx, last_idx;

   always_comb begin
      synced_d      = synced_q;
      n_log2_d      = n_log2_q;
      exp_idx_d     = exp_idx_q;
      s1_valid_d    = s1_valid_q;
      s1_data_d     = s1_data_q;
      s1_idx_d      = s1_idx_q;
      s1_sof_d      = s1_sof_q;
      s1_eof_d      = s1_eof_q;
      rom_addr_d    = rom_addr_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_twiddle_d = out_twiddle_q;
      out_idx_d     = out_idx_q;
      out_sof_d     = out_sof_q;
      out_eof_d     = out_eof_q;
      err_sof_d     = 1'b0;

      adv2   = ~out_valid_q | strm.out_ready;
      adv1   = ~s1_valid_q | adv2;
      accept = strm.in_valid & adv1;

      nl_cfg = (cfg_log2n < 3'd4) ? 3'd4 : cfg_log2n;
      if (strm.in_sof) begin
         cur_idx = 7'd0;
         cur_nl  = nl_cfg;
      end else begin
         cur_idx = exp_idx_q;
         cur_nl  = n_log2_q;
      end
      last_idx = 7'h7f >> (3'd7 - cur_nl);
      is_last  = (cur_idx == last_idx);

      // Before the first sof the index is meaningless, so such beats are swallowed.
      take = accept & (synced_q | strm.in_sof);

      if (take) begin
         synced_d  = 1'b1;
         n_log2_d  = cur_nl;
         exp_idx_d = is_last ? 7'd0 : 7'(cur_idx + 7'd1);
         err_sof_d = strm.in_sof & (exp_idx_q != 7'd0);
      end

      if (adv1) begin
         s1_valid_d = take;
         if (take) begin
            s1_data_d  = strm.in_data;
            s1_idx_d   = cur_idx;
            s1_sof_d   = strm.in_sof;
            s1_eof_d   = is_last;
            // Scale the index onto the 128-point ROM grid.
            rom_addr_d = cur_idx << (3'd7 - cur_nl);
         end
      end

      if (adv2) begin
         out_valid_d = s1_valid_q;
         out_sof_d   = s1_valid_q & s1_sof_q;
         out_eof_d   = s1_valid_q & s1_eof_q;
         if (s1_valid_q) begin
            out_data_d    = s1_data_q;
            out_twiddle_d = rom_data;
            out_idx_d     = s1_idx_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         synced_q      <= 1'b0;
         n_log2_q      <= '0;
         exp_idx_q     <= '0;
         s1_valid_q    <= 1'b0;
         s1_data_q     <= '0;
         s1_idx_q      <= '0;
         s1_sof_q      <= 1'b0;
         s1_eof_q      <= 1'b0;
         rom_addr_q    <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_twiddle_q <= '0;
         out_idx_q     <= '0;
         out_sof_q     <= 1'b0;
         out_eof_q     <= 1'b0;
         err_sof_q     <= 1'b0;
      end else begin
         synced_q      <= synced_d;
         n_log2_q      <= n_log2_d;
         exp_idx_q     <= exp_idx_d;
         s1_valid_q    <= s1_valid_d;
         s1_data_q     <= s1_data_d;
         s1_idx_q      <= s1_idx_d;
         s1_sof_q      <= s1_sof_d;
         s1_eof_q      <= s1_eof_d;
         rom_addr_q    <= rom_addr_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_twiddle_q <= out_twiddle_d;
         out_idx_q     <= out_idx_d;
         out_sof_q     <= out_sof_d;
         out_eof_q     <= out_eof_d;
         err_sof_q     <= err_sof_d;
      end
   end

   assign strm.in_ready    = adv1;
   assign strm.out_valid   = out_valid_q;
   assign strm.out_data    = out_data_q;
   assign strm.out_twiddle = out_twiddle_q;
   assign strm.out_idx     = out_idx_q;
   assign strm.out_sof     = out_sof_q;
   assign strm.out_eof     = out_eof_q;
   assign rom_addr         = rom_addr_q;
   assign err_sof          = err_sof_q;

endmodule

// File: tb/tb_r4u3_twiddle_seq.sv
// tb/tb_r4u3_twiddle_seq.sv - directed self-checking bench for r4u3_twiddle_seq
module tb_r4u3_twiddle_seq;
   localparam int DW  = 16;
   localparam int CWT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  cfg_log2n;
   logic [6:0]  rom_addr;
   logic [31:0] rom_data;
   logic        err_sof;

   always #5 clk = ~clk;

   r4u3_twiddle_seq_if #(.DATA_W(DW), .CW(CWT)) sif ();

   r4u3_twiddle_seq #(.DATA_W(DW), .CW(CWT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_log2n (cfg_log2n),
      .strm      (sif),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .err_sof   (err_sof)
   );

   function automatic logic [31:0] rom_fn(input logic [6:0] a);
      return {8'hA0, 1'b0, a, 8'h5C, 1'b1, ~a};
   endfunction

   assign rom_data = rom_fn(rom_addr);

   typedef struct {
      logic [31:0] data;
      logic [6:0]  idx;
      logic        sof;
      logic        eof;
      logic [31:0] tw;
   } exp_t;

   exp_t exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int err_cnt = 0;
   int ov_cnt = 0;
   int ir_low_cnt = 0;
   int bp_cnt = 0;
   logic bp_en = 1'b0;
   logic prev_stall = 1'b0;
   logic [31:0] held_data, held_tw;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // out_ready pattern 1,0,0,1 repeating
   always @(posedge clk) begin
      #1;
      if (bp_en) begin
         sif.out_ready = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
         bp_cnt++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (err_sof) err_cnt++;
         if (sif.out_valid) ov_cnt++;
         if (bp_en && !sif.in_ready) ir_low_cnt++;
         if (prev_stall) begin
            check("hold_valid", 64'(sif.out_valid), 64'd1);
            check("hold_data", 64'(sif.out_data), 64'(held_data));
            check("hold_twiddle", 64'(sif.out_twiddle), 64'(held_tw));
         end
         if (sif.out_valid && sif.out_ready) begin
            if (exp_q.size() == 0) begin
               check("pair_expected", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 64'(sif.out_data), 64'(e.data));
               check("out_idx", 64'(sif.out_idx), 64'(e.idx));
               check("out_sof", 64'(sif.out_sof), 64'(e.sof));
               check("out_eof", 64'(sif.out_eof), 64'(e.eof));
               check("out_twiddle", 64'(sif.out_twiddle), 64'(e.tw));
            end
         end
         prev_stall = sif.out_valid && !sif.out_ready;
         held_data  = sif.out_data;
         held_tw    = sif.out_twiddle;
      end
   end

   task automatic send_beat(input logic sof, input logic [31:0] data, input logic push,
                            input logic [6:0] eidx, input logic eeof, input logic [2:0] enl);
      int t;
      logic [6:0] ea;
      exp_t e;
      sif.in_valid = 1'b1;
      sif.in_sof   = sof;
      sif.in_data  = data;
      t = 0;
      forever begin
         @(negedge clk);
         if (sif.in_ready) break;
         t++;
         if (t > 50) begin
            check("in_ready_timeout", 64'(sif.in_ready), 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      sif.in_valid = 1'b0;
      if (push) begin
         ea = eidx << (3'd7 - enl);
         check("rom_addr", 64'(rom_addr), 64'(ea));
         e.data = data; e.idx = eidx; e.sof = sof; e.eof = eeof; e.tw = rom_fn(ea);
         exp_q.push_back(e);
      end else begin
         check("rom_addr_unsynced", 64'(rom_addr), 64'd0);
      end
   endtask

   task automatic frame(input logic [2:0] cfg, input logic [2:0] cfg_after, input int nbeats,
                        input int nl, input logic exp_err);
      logic empty;
      int idx;
      empty = (exp_q.size() == 0);
      cfg_log2n = cfg;
      for (int i = 0; i < nbeats; i++) begin
         idx = i % (1 << nl);
         send_beat(i == 0, {16'(i * 37 + nl), 16'hB000 ^ 16'(i)}, 1'b1, 7'(idx),
                   idx == ((1 << nl) - 1), 3'(nl));
         if (i == 0) begin
            cfg_log2n = cfg_after;
            check("err_sof_on_sof", 64'(err_sof), 64'(exp_err));
            if (empty) check("latency_1cyc_no_valid", 64'(sif.out_valid), 64'd0);
         end
         if (i == 1) begin
            check("err_sof_pulse_end", 64'(err_sof), 64'd0);
            if (empty) check("latency_2cyc_valid", 64'(sif.out_valid), 64'd1);
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      sif.in_valid  = 1'b0;
      sif.in_sof    = 1'b0;
      sif.in_data   = '0;
      sif.out_ready = 1'b1;
      cfg_log2n     = 3'd7;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(sif.out_valid), 64'd0);
      check("rst_rom_addr", 64'(rom_addr), 64'd0);
      check("rst_err_sof", 64'(err_sof), 64'd0);
      check("rst_out_idx", 64'(sif.out_idx), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(sif.in_ready), 64'd1);

      // unsynced beats are discarded
      ov_cnt = 0;
      for (int i = 0; i < 4; i++) send_beat(1'b0, 32'hDEAD_0000 + 32'(i), 1'b0, 7'd0, 1'b0, 3'd7);
      repeat (4) @(posedge clk);
      #1;
      check("unsynced_no_out", 64'(ov_cnt), 64'd0);

      // 128-point frame, cfg change mid-frame ignored
      frame(3'd7, 3'd4, 128, 7, 1'b0);
      drain();

      // 16-point frame plus one wrap beat without sof
      frame(3'd4, 3'd4, 17, 4, 1'b0);
      drain();

      // 32-point frame under backpressure; sof arrives at expected idx 1
      bp_cnt = 0;
      bp_en = 1'b1;
      ir_low_cnt = 0;
      frame(3'd5, 3'd5, 32, 5, 1'b1);
      drain();
      bp_en = 1'b0;
      sif.out_ready = 1'b1;
      check("bp_in_ready_low_seen", 64'(ir_low_cnt > 0), 64'd1);

      // 64-point frame interrupted by sof at idx 5, new length 32
      frame(3'd6, 3'd6, 5, 6, 1'b0);
      frame(3'd5, 3'd7, 32, 5, 1'b1);
      drain();

      // cfg 2 clamps to 16 points
      frame(3'd2, 3'd2, 16, 4, 1'b0);
      drain();
      check("err_sof_pulses", 64'(err_cnt), 64'd2);

      // reset mid-stream with a held output pair
      sif.out_ready = 1'b0;
      cfg_log2n = 3'd7;
      sif.in_valid = 1'b1;
      sif.in_sof = 1'b1;
      sif.in_data = 32'h1234_5678;
      @(posedge clk);
      #1;
      sif.in_sof = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("pre_reset_out_valid", 64'(sif.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      sif.in_valid = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(sif.out_valid), 64'd0);
      check("mid_rst_out_data", 64'(sif.out_data), 64'd0);
      check("mid_rst_out_twiddle", 64'(sif.out_twiddle), 64'd0);
      check("mid_rst_out_sof", 64'(sif.out_sof), 64'd0);
      check("mid_rst_rom_addr", 64'(rom_addr), 64'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 64'(sif.in_ready), 64'd1);
      sif.out_ready = 1'b1;
      ov_cnt = 0;
      for (int i = 0; i < 4; i++) send_beat(1'b0, 32'hBEEF_0000 + 32'(i), 1'b0, 7'd0, 1'b0, 3'd7);
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_no_out", 64'(ov_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/r4u3_twiddle_seq.md
Name: r4u3_twiddle_seq

Overview:
- Read-side sequencer for the radix-4 unit 3 twiddle ROM (128 entries, 7-bit address, 2*`COEF_WIDTH data).
- Accepts the unit-3 sample stream, derives the ROM address from the in-frame sample index and the configured point size, and pairs each sample with its twiddle factor.
- Output stream is registered, with a valid/ready handshake, and feeds the unit-3 complex multiplier.

Parameters:
- DATA_W, 16, width of each real/imag component of a sample; sample bus is 2*DATA_W.
- CW, `COEF_WIDTH, width of each twiddle component; rom_data/out_twiddle are 2*CW.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_log2n  in  3  log2 of frame length (4..7 = 16..128 points); sampled only on accepted sof beat
- in_valid  in  1  input sample valid
- in_ready  out  1  input accept
- in_sof  in  1  first sample of frame
- in_data  in  2*DATA_W  {re,im} sample
- rom_addr  out  7  twiddle ROM address (registered)
- rom_data  in  2*CW  twiddle ROM data, combinational from rom_addr
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accept
- out_sof  out  1  first pair of frame
- out_eof  out  1  last pair of frame (idx = N-1)
- out_data  out  2*DATA_W  delayed sample
- out_twiddle  out  2*CW  twiddle for that sample
- out_idx  out  7  in-frame sample index
- err_sof  out  1  one-cycle pulse: sof received mid-frame

Behaviour:
- Reset (async, rst_n low): all outputs, rom_addr, and all state are 0. Internal synced = 0; in_ready = 1 after reset.
- Accept occurs when in_valid & in_ready.
- Two-stage pipeline:
  - S1 holds data, idx, sof, eof and drives rom_addr.
  - S2 captures S1 plus rom_data.
  - Latency from accept to out_valid is 2 cycles.
- Stall rules:
  - adv2 = ~out_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1.
  - While stalled, S1/S2 and rom_addr hold, so rom_data stays stable.
  - Full throughput: one pair per cycle when out_ready stays 1.
- Index counter idx[6:0] and frame length n_log2:
  - Accepted beat with in_sof: idx = 0; n_log2 = max(cfg_log2n, 4) (values 0..3 clamp to 4); synced = 1.
  - Otherwise idx = previous+1. At idx = 2^n_log2 - 1 the beat is flagged eof and the next expected index wraps to 0.
  - After wrap without in_sof: next frame continues at idx 0 with the same n_log2. Back-to-back frames without sof are legal.
- Address: rom_addr = idx << (7 - n_log2), truncated to 7 bits. The ROM is always addressed on its 128-point grid.
- Unsynced (synced = 0, i.e. since reset, no sof seen):
  - Accepted beats are consumed and discarded; they do not enter S1.
  - in_ready stays governed by the stall rule.
- Mid-frame sof: in_sof accepted while the expected idx != 0 restarts at idx 0, re-samples cfg_log2n, and pulses err_sof on the following cycle. The pair carrying that sof is emitted normally with out_sof = 1.
- cfg_log2n changes between sof beats are ignored.
- out_sof/out_eof are qualified by out_valid and held with the pair during stall. err_sof is not affected by stalls.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 -> all outputs 0 immediately, in_ready=1 after release; beats without sof -> no out_valid.
- cfg_log2n=7, sof then 127 more beats, out_ready=1 -> rom_addr sequence 0,1,...,127; out_valid 2 cycles after first accept; out_eof on idx 127; out_twiddle equals ROM[idx] for every pair.
- cfg_log2n=4, 16-beat frame -> rom_addr 0,8,16,...,120; out_eof at idx 15; a 17th beat without sof gives idx 0, rom_addr 0.
- Backpressure: out_ready toggles 1,0,0,1 every 4 cycles during a 32-point frame -> no lost or duplicated pairs; out_data/out_twiddle held while out_ready=0; in_ready=0 when both stages are full.
- Mid-frame sof at idx 5 of a 64-point frame with cfg_log2n changed to 5 -> err_sof one pulse; next pair idx 0, out_sof=1; frame length 32, eof at idx 31.
- cfg_log2n=2 on sof -> clamped to 16-point frame, rom_addr step 8.
